// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler and scoreboard for the integer register file.
// Arbitrates the single register-file write port between the ALU and LSU
// writeback channels (round-robin, valid/ready). It registers the winning
// write onto the port and keeps a per-register busy bit that decode uses to
// detect read-after-write hazards.
module regfile_wb_scheduler #(
  parameter int REGF_WIDTH = 32,
  parameter int REGF_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  alloc_valid,
  input  logic [4:0]            alloc_addr,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [4:0]            alu_addr,
  input  logic [REGF_WIDTH-1:0] alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [4:0]            lsu_addr,
  input  logic [REGF_WIDTH-1:0] lsu_data,
  output logic                  reg_write,
  output logic [4:0]            waddr,
  output logic [REGF_WIDTH-1:0] wdata,
  input  logic [4:0]            raddr1,
  input  logic [4:0]            raddr2,
  output logic                  hazard1,
  output logic                  hazard2,
  output logic [REGF_DEPTH-1:0] busy
);

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_LSU = 1'b1
  } grant_e;

  grant_e                  last_grant_q, last_grant_d;
  logic                    reg_write_q, reg_write_d;
  logic [4:0]              waddr_q, waddr_d;
  logic [REGF_WIDTH-1:0]   wdata_q, wdata_d;
  logic [REGF_DEPTH-1:0]   busy_q, busy_d;

  logic                    grant_alu;
  logic                    grant_lsu;
  logic [4:0]              sel_addr;
  logic [REGF_WIDTH-1:0]   sel_data;

  // Round-robin grant: a lone requester wins, a tie goes to the channel that
  // did not win last time; flush blocks every transfer for its cycle.
  always_comb begin
    grant_alu    = 1'b0;
    grant_lsu    = 1'b0;
    last_grant_d = last_grant_q;
    if (!flush) begin
      grant_alu = alu_valid && (!lsu_valid || (last_grant_q == GRANT_LSU));
      grant_lsu = lsu_valid && (!alu_valid || (last_grant_q == GRANT_ALU));
    end
    if (grant_alu) begin
      last_grant_d = GRANT_ALU;
    end else if (grant_lsu) begin
      last_grant_d = GRANT_LSU;
    end
    alu_ready = grant_alu;
    lsu_ready = grant_lsu;
  end

  // Output stage: load the accepted write; writes to x0 complete the
  // handshake but never reach the port, and address/data hold when idle.
  always_comb begin
    sel_addr    = grant_alu ? alu_addr : lsu_addr;
    sel_data    = grant_alu ? alu_data : lsu_data;
    reg_write_d = (grant_alu || grant_lsu) && (sel_addr != 5'd0);
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    if (reg_write_d) begin
      waddr_d = sel_addr;
      wdata_d = sel_data;
    end
  end

  // Scoreboard: clear on the committing edge, set on allocation (set wins a
  // same-register collision), flush wipes everything and drops the alloc.
  always_comb begin
    busy_d = busy_q;
    if (reg_write_q) begin
      busy_d[waddr_q] = 1'b0;
    end
    if (alloc_valid && (alloc_addr != 5'd0)) begin
      busy_d[alloc_addr] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  // State registers; reset drops any pending write and all busy bits at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= GRANT_LSU;
      reg_write_q  <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      busy_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      reg_write_q  <= reg_write_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      busy_q       <= busy_d;
    end
  end

  assign reg_write = reg_write_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign busy      = busy_q;
  assign hazard1   = busy_q[raddr1];
  assign hazard2   = busy_q[raddr2];

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Writeback scheduler and scoreboard for the integer register file. It shares the register file's single write port between two writeback requesters, the ALU and the LSU, using round-robin arbitration with valid/ready handshakes. It registers the winning write onto the port and tracks a per-register busy bit so decode can stall on read-after-write hazards. It sits between the execute/memory stages and `register_file`, driving that block's `reg_write`/`waddr`/`wdata` inputs.

## Interface
- `REGF_WIDTH`, 32, data width of one register
- `REGF_DEPTH`, 32, number of architectural registers (x0 hardwired zero)
- `clk` in 1: single clock; all state updates on its rising edge
- `rst` in 1: asynchronous, active-high reset
- `flush` in 1: synchronous pipeline flush
- `alloc_valid` in 1: decode issued an instruction that writes a register
- `alloc_addr` in 5: destination register of that issue
- `alu_valid` in 1, `alu_ready` out 1, `alu_addr` in 5, `alu_data` in REGF_WIDTH: ALU writeback channel
- `lsu_valid` in 1, `lsu_ready` out 1, `lsu_addr` in 5, `lsu_data` in REGF_WIDTH: LSU writeback channel
- `reg_write` out 1, `waddr` out 5, `wdata` out REGF_WIDTH: registered write port to the register file
- `raddr1` in 5, `raddr2` in 5: decode source addresses
- `hazard1` out 1, `hazard2` out 1: source is pending a write (combinational)
- `busy` out REGF_DEPTH: scoreboard vector; bit 0 is always 0

## Operation
- **Arbiter state.** `last_grant` is one bit, ALU or LSU.
  - Only one channel valid: that channel is granted.
  - Both valid: the channel not equal to `last_grant` is granted.
  - `last_grant` updates only on an accepted transfer.
- **Ready.** `*_ready` is combinational: high for the granted channel, low for the other.
  - Both readies are low while `flush` is high.
- **Transfer.** A transfer occurs when `valid && ready` at the rising edge.
  - Requesters must hold `addr`/`data` stable while valid and not ready.
- **Output stage.** An accepted transfer with `addr != 0` loads `waddr`/`wdata` and sets `reg_write=1` at that edge.
  - With no transfer, `reg_write` returns to 0 at the next edge. `waddr`/`wdata` hold their last values.
  - A transfer to x0 is accepted (ready handshake completes) but leaves `reg_write=0`.
- **Scoreboard, set.** `busy[alloc_addr]` is set at the edge where `alloc_valid=1` and `alloc_addr != 0`. A set on an already-busy register leaves it busy.
- **Scoreboard, clear.** `busy[waddr]` is cleared at the edge where `reg_write=1`, which is the same edge the register file captures the data.
- **Set/clear collision.** Same register in the same cycle: the set wins, so the bit stays busy.
- **Hazards.** `hazardN = busy[raddrN]`. x0 never flags.
- **Flush.**
  - Clears all busy bits at the edge.
  - Blocks new transfers in that cycle.
  - A write already in the output stage still completes (`reg_write` stays high for its cycle).
  - An alloc in the same cycle as `flush` is ignored.

## Timing
- Reset values:
  - `reg_write=0`, `waddr=0`, `wdata=0`, `busy=0`.
  - `last_grant=LSU`, so the first tie goes to the ALU.
  - `alu_ready`/`lsu_ready` follow the arbiter equations with the reset state.
- Reset asserted mid-operation immediately drops `reg_write` and any pending write. Busy clears asynchronously.
- Latency: handshake at edge N puts `reg_write=1` during cycle N+1. The register file updates at edge N+1, and `busy` clears at edge N+1.
- Throughput: one write per cycle, sustained. Under continuous dual requests the grant alternates every cycle.
- The output port never backpressures; there is no internal buffering beyond the single output register.
- Hazard path: combinational from `raddr*` and `busy`, with no same-cycle bypass. A read in cycle N+1 of a register written in N+1 still sees `hazard=1`.

## Test plan
1. **Reset.** Assert `rst` mid-stream with `reg_write=1` -> `reg_write`, `busy` and `waddr` go to 0 immediately. After release, both channels valid -> `alu_ready=1`, `lsu_ready=0`.
2. **Round-robin.** Both channels valid for 4 cycles (ALU x5=0x11, LSU x6=0x22) -> grants ALU, LSU, ALU, LSU. `reg_write` stays high from cycle 2, with `waddr` alternating 5, 6.
3. **Scoreboard.**
   - alloc x7 -> `busy[7]=1` and `hazard1=1` for `raddr1=7`.
   - LSU writes x7=0xDEAD -> `hazard1` drops one cycle after `reg_write` pulses.
4. **Collision.** Alloc x9 in the same cycle that `reg_write` commits x9 -> `busy[9]` stays 1.
5. **x0 handling.**
   - ALU write to x0 -> `alu_ready=1`, `reg_write` stays 0.
   - Alloc x0 -> `busy` unchanged and `hazard` for `raddr=0` stays 0.
6. **Flush.**
   - Busy={3,4}, both channels valid, `flush=1` -> both readies 0, busy=0 next cycle, and an in-flight x3 write still pulses `reg_write`.
   - Alloc x12 in the same cycle is ignored.
